// File: rtl/sea_de_iter.sv
// sea_de_iter: iterative SEA decryption, one inverse round per enabled RUN cycle.
// Optional macro SEA_DE_ITER_ZEROIZE_EN clears L/R/K (and thus lio/rio) when the
// result is handed off.
module sea_de_iter #(
    parameter int NR = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] li,
    input  logic [47:0] ri,
    input  logic [47:0] ki,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] lio,
    output logic [47:0] rio,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0] LAST = 8'(NR - 1);
    // 3-bit SEA sbox, entry i at bits [3i+:3]: {0,5,6,7,4,3,1,2}
    localparam logic [23:0] LUT = {3'd2, 3'd1, 3'd3, 3'd4, 3'd7, 3'd6, 3'd5, 3'd0};

    // Bitsliced sbox over each triple of words: bit j of words 3t..3t+2 forms one 3-bit symbol
    function automatic logic [47:0] sbox(input logic [47:0] x);
        logic [47:0] y;
        logic [2:0]  s;
        y = '0;
        for (int t = 0; t < 2; t++)
            for (int j = 0; j < 8; j++) begin
                s = LUT[3 * {x[24*t+16+j], x[24*t+8+j], x[24*t+j]} +: 3];
                {y[24*t+16+j], y[24*t+8+j], y[24*t+j]} = s;
            end
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [47:0] l_q, l_d, r_q, r_d, k_q, k_d;
    logic [7:0]  rnd_q, rnd_d;
    logic        in_ready_q, out_valid_q, busy_q;
    logic [47:0] sum, sub, f;

    // Round function: word-wise add, sbox, then rotate words up by one position
    always_comb begin
        sum = '0;
        for (int i = 0; i < 6; i++) sum[8*i+:8] = r_q[8*i+:8] + k_q[8*i+:8];
        sub = sbox(sum);
        f   = {sub[39:0], sub[47:40]};
    end

    // Next-state and datapath; everything holds while ena is low
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        k_d     = k_q;
        rnd_d   = rnd_q;
        if (ena) begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = RUN;
                    l_d     = li;
                    r_d     = ri;
                    k_d     = ki;
                    rnd_d   = '0;
                end
                RUN: begin
                    l_d     = r_q;
                    r_d     = l_q ^ f;
                    rnd_d   = (rnd_q == LAST) ? rnd_q : rnd_q + 8'd1;
                    state_d = (rnd_q == LAST) ? DONE : RUN;
                end
                DONE: if (out_ready) begin
                    state_d = IDLE;
`ifdef SEA_DE_ITER_ZEROIZE_EN
                    l_d = '0;
                    r_d = '0;
                    k_d = '0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and handshake outputs, all registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            k_q         <= k_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= state_d == IDLE;
            out_valid_q <= state_d == DONE;
            busy_q      <= state_d == RUN;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign lio       = l_q;
    assign rio       = r_q;
endmodule

// File: doc/sea_de_iter.md
SEA_DE_ITER -- requirements
Module: sea_de_iter

Interface
REQ-001 Parameter NR, default 8, number of decryption rounds; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 ena  in  1  global enable; when 0, all registers hold value.
REQ-005 in_valid  in  1  ciphertext block presented.
REQ-006 in_ready  out  1  block accepted on the cycle in_valid=1, in_ready=1 and ena=1.
REQ-007 li  in  48  ciphertext left half.
REQ-008 ri  in  48  ciphertext right half.
REQ-009 ki  in  48  round key, sampled with the block.
REQ-010 out_valid  out  1  plaintext available.
REQ-011 out_ready  in  1  sink accepts plaintext.
REQ-012 lio  out  48  plaintext left half.
REQ-013 rio  out  48  plaintext right half.
REQ-014 busy  out  1  1 while in RUN state.

Function
REQ-015 The datapath SHALL treat each 48-bit half as six 8-bit words.
REQ-016 The round function F(X,K) SHALL be the team's SEA round function: word-wise add mod 256, then the existing sbox module, then the word rotation.
REQ-017 The block SHALL invert one encryption round per RUN cycle: L_next = R, R_next = L xor F(R,K).
REQ-018 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-019 IDLE: in_ready=1; on accept, load L<=li, R<=ri, K<=ki, rnd<=0, and go to RUN.
REQ-020 RUN: in_ready=0; apply one round per enabled cycle and increment rnd; after round NR (rnd=NR-1), go to DONE.
REQ-021 DONE: out_valid=1, with lio/rio holding the final L/R.
REQ-022 DONE: on out_valid and out_ready with ena=1, go to IDLE.
REQ-023 Accept-to-out_valid latency SHALL be exactly NR+1 enabled cycles.
REQ-024 lio/rio SHALL stay stable while out_valid=1 and out_ready=0; no block is dropped under backpressure.
REQ-025 in_ready SHALL be 0 in RUN and DONE; there is no input pipelining and in_valid is ignored there.
REQ-026 out_valid SHALL never rise in the same cycle as the accept.
REQ-027 When ena=0, the FSM, counter and datapath SHALL freeze; in_ready and out_valid still reflect the state, but no handshake completes.
REQ-028 The round counter SHALL be 8 bits wide and SHALL never wrap past NR-1.

Reset
REQ-029 On rst_n=0, the block SHALL asynchronously enter IDLE.
REQ-030 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, lio=0, rio=0, L/R/K=0, rnd=0.
REQ-031 Reset mid-RUN or mid-DONE SHALL discard the block in flight with no output.
REQ-032 After rst_n is released, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-033 Macro SEA_DE_ITER_ZEROIZE_EN defined: on the DONE->IDLE transition, the L, R and K registers and lio/rio SHALL be cleared to 0 in the same edge.
REQ-034 Macro undefined: the registers SHALL retain their last values in IDLE; lio/rio SHALL keep the last plaintext.
REQ-035 The handshake timing SHALL be identical with and without the macro.

Verification
REQ-036 NR=1, K=0, li=0, ri=0: out_valid exactly 2 cycles after accept, with lio=0 and rio=F(0,0).
REQ-037 NR=8 round trip: random li/ri/ki encrypted by 8 rounds of the encryption core, then fed in; lio/rio SHALL equal the original plaintext.
REQ-038 Backpressure: hold out_ready=0 for 10 cycles in DONE; outputs stay stable, in_ready=0, and the next block is accepted only after out_ready=1.
REQ-039 Assert rst_n=0 at round 3 of NR=8: outputs go to reset values immediately and no out_valid follows.
REQ-040 Drop ena for 5 cycles mid-RUN: latency grows by exactly 5 cycles and the result is unchanged.
REQ-041 With SEA_DE_ITER_ZEROIZE_EN: after the output handshake, lio=rio=0 the next cycle; without the macro, the last plaintext is retained.
